// File: rtl/bcd_seq_converter_if.sv
// Handshake and result bundle between a binary source and the BCD converter.
interface bcd_seq_converter_if #(
    parameter int WIDTH = 13
);
    logic             start;
    logic [WIDTH-1:0] bin;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [3:0]       th;
    logic [3:0]       hu;
    logic [3:0]       te;
    logic [3:0]       on;

    modport master (
        output start, bin,
        input  busy, done, ovf, th, hu, te, on
    );

    modport slave (
        input  start, bin,
        output busy, done, ovf, th, hu, te, on
    );
endinterface

// File: rtl/bcd_seq_converter.sv
// Iterative shift-add-3 (double-dabble) converter from binary to four packed BCD digits.
// Optional macro BCD_SATURATE_EN: out-of-range values display 9999 instead of value mod 10000.
module bcd_seq_converter #(
    parameter int WIDTH = 13
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd_seq_converter_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_LOAD
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] r_cap;
    logic [15:0]      r_scratch;
    logic [15:0]      r_digits;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic             r_ovf;
    logic             w_ovf;
    logic [15:0]      w_load;

    // Add 3 to every nibble that is 5 or more, so the following left shift carries into the next decade.
    function automatic logic [15:0] add3(input logic [15:0] s);
        logic [15:0] r;
        r = s;
        for (int i = 0; i < 4; i++) begin
            if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign w_ovf = (16'(r_cap) > 16'd9999);

    always_comb begin
        w_load = r_scratch;
`ifdef BCD_SATURATE_EN
        if (w_ovf) w_load = 16'h9999;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_SHIFT;
            S_SHIFT: if (r_cnt == CNT_W'(1)) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg   <= '0;
            r_cap     <= '0;
            r_scratch <= '0;
            r_digits  <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_shreg   <= bus.bin;
                        r_cap     <= bus.bin;
                        r_scratch <= '0;
                        r_cnt     <= CNT_W'(WIDTH);
                    end
                end
                S_SHIFT: begin
                    // Carry out of the thousands nibble drops off, leaving value mod 10000.
                    r_scratch <= 16'({add3(r_scratch), r_shreg[WIDTH-1]});
                    r_shreg   <= r_shreg << 1;
                    r_cnt     <= r_cnt - CNT_W'(1);
                end
                S_LOAD: begin
                    r_digits <= w_load;
                    r_ovf    <= w_ovf;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = r_done;
    assign bus.ovf  = r_ovf;
    assign bus.th   = r_digits[15:12];
    assign bus.hu   = r_digits[11:8];
    assign bus.te   = r_digits[7:4];
    assign bus.on   = r_digits[3:0];
endmodule

// File: tb/tb_bcd_seq_converter.sv
// Self-checking bench for bcd_seq_converter: a 13-bit and a 14-bit instance share clock and reset.
module tb_bcd_seq_converter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd_seq_converter_if #(.WIDTH(13)) ifa ();
    bcd_seq_converter_if #(.WIDTH(14)) ifb ();

    bcd_seq_converter #(.WIDTH(13)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    bcd_seq_converter #(.WIDTH(14)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    int n_pass = 0;
    int n_tot  = 0;

    typedef struct {
        int v;
        int exp_bcd;
        int exp_ovf;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Reference: decimal digits of the value, wrapped or clamped into four decades.
    function automatic int model_bcd(input int v);
        int m;
`ifdef BCD_SATURATE_EN
        m = (v > 9999) ? 9999 : (v % 10000);
`else
        m = v % 10000;
`endif
        return ((m / 1000) << 12) | (((m / 100) % 10) << 8) | (((m / 10) % 10) << 4) | (m % 10);
    endfunction

    function automatic int dig_a();
        return int'({ifa.th, ifa.hu, ifa.te, ifa.on});
    endfunction

    function automatic int dig_b();
        return int'({ifb.th, ifb.hu, ifb.te, ifb.on});
    endfunction

    // Called at a falling edge; returns at the falling edge where done is seen (or after a bound).
    task automatic conv_a(input int v, output int lat, output int busy_n, output int stable);
        int prev;
        prev = dig_a();
        ifa.bin = 13'(v);
        ifa.start = 1'b1;
        busy_n = 0;
        stable = 1;
        @(negedge clk);
        ifa.start = 1'b0;
        ifa.bin = 13'($urandom);
        lat = 1;
        while (!ifa.done && lat < 40) begin
            if (ifa.busy) busy_n++;
            if (dig_a() != prev) stable = 0;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic conv_b(input int v, output int lat);
        ifb.bin = 14'(v);
        ifb.start = 1'b1;
        @(negedge clk);
        ifb.start = 1'b0;
        ifb.bin = 14'($urandom);
        lat = 1;
        while (!ifb.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        vec_t tbl[10];
        int lat, busy_n, stable, dones, first, idx, v;

        tbl[0] = '{0,    'h0000, 0};
        tbl[1] = '{8191, 'h8191, 0};
        tbl[2] = '{1234, 'h1234, 0};
        tbl[3] = '{9,    'h0009, 0};
        tbl[4] = '{1000, 'h1000, 0};
        tbl[5] = '{4095, 'h4095, 0};
        tbl[6] = '{5,    'h0005, 0};
        tbl[7] = '{7999, 'h7999, 0};
        tbl[8] = '{10,   'h0010, 0};
        tbl[9] = '{999,  'h0999, 0};

        ifa.start = 1'b0; ifa.bin = '0;
        ifb.start = 1'b0; ifb.bin = '0;
        repeat (3) @(negedge clk);
        check("reset_digits", dig_a(), 0);
        check("reset_busy", int'(ifa.busy), 0);
        check("reset_done", int'(ifa.done), 0);
        check("reset_ovf", int'(ifa.ovf), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table of known conversions on the 13-bit instance
        for (int i = 0; i < 10; i++) begin
            conv_a(tbl[i].v, lat, busy_n, stable);
            check($sformatf("tbl%0d_latency", i), lat, 15);
            check($sformatf("tbl%0d_busy_cycles", i), busy_n, 14);
            check($sformatf("tbl%0d_hold_until_done", i), stable, 1);
            check($sformatf("tbl%0d_digits", i), dig_a(), tbl[i].exp_bcd);
            check($sformatf("tbl%0d_ovf", i), int'(ifa.ovf), tbl[i].exp_ovf);
            @(negedge clk);
            check($sformatf("tbl%0d_done_one_cycle", i), int'(ifa.done), 0);
        end

        // Start pulsed mid-conversion is dropped
        ifa.bin = 13'd1234;
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        repeat (4) @(negedge clk);
        ifa.bin = 13'd4321;
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        idx = 6; dones = 0; first = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            idx++;
            if (ifa.done) begin
                dones++;
                if (first == 0) first = idx;
            end
        end
        check("ignore_done_count", dones, 1);
        check("ignore_done_time", first, 15);
        check("ignore_digits", dig_a(), 'h1234);

        // Start during the done cycle is taken immediately
        conv_a(9, lat, busy_n, stable);
        check("b2b_first_digits", dig_a(), 'h0009);
        conv_a(1000, lat, busy_n, stable);
        check("b2b_done_spacing", lat, 15);
        check("b2b_second_digits", dig_a(), 'h1000);

        // Reset in the middle of a conversion
        ifa.bin = 13'd5555;
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_digits", dig_a(), 0);
        check("midrst_busy", int'(ifa.busy), 0);
        check("midrst_ovf", int'(ifa.ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (ifa.done) dones++;
        end
        check("midrst_no_done", dones, 0);
        conv_a(42, lat, busy_n, stable);
        check("midrst_after_latency", lat, 15);
        check("midrst_after_digits", dig_a(), 'h0042);
        @(negedge clk);

        // Random values on the 13-bit instance against the model
        for (int i = 0; i < 30; i++) begin
            v = int'($urandom_range(0, 8191));
            conv_a(v, lat, busy_n, stable);
            check($sformatf("rnd13_%0d_latency", v), lat, 15);
            check($sformatf("rnd13_%0d_digits", v), dig_a(), model_bcd(v));
            check($sformatf("rnd13_%0d_ovf", v), int'(ifa.ovf), 0);
        end

        // 14-bit instance: overflow boundary
        conv_b(16383, lat);
        check("w14_16383_latency", lat, 16);
`ifdef BCD_SATURATE_EN
        check("w14_16383_digits", dig_b(), 'h9999);
`else
        check("w14_16383_digits", dig_b(), 'h6383);
`endif
        check("w14_16383_ovf", int'(ifb.ovf), 1);
        conv_b(9999, lat);
        check("w14_9999_digits", dig_b(), 'h9999);
        check("w14_9999_ovf", int'(ifb.ovf), 0);
        conv_b(10000, lat);
        check("w14_10000_digits", dig_b(), model_bcd(10000));
        check("w14_10000_ovf", int'(ifb.ovf), 1);
        for (int i = 0; i < 20; i++) begin
            v = int'($urandom_range(0, 16383));
            conv_b(v, lat);
            check($sformatf("rnd14_%0d_latency", v), lat, 16);
            check($sformatf("rnd14_%0d_digits", v), dig_b(), model_bcd(v));
            check($sformatf("rnd14_%0d_ovf", v), int'(ifb.ovf), (v > 9999) ? 1 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
